// File: rtl/prog_loader_ctrl.sv
// Program loader / CPU run controller: streams an image into CPU IR/DM memories, resets the CPU, runs it and times the run.
// Optional RUN watchdog enabled by defining LOADER_TIMEOUT_EN.
module prog_loader_ctrl #(
    parameter int unsigned RST_CYCLES     = 10,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        load_is_data,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        load_last,
    input  logic        cpu_done,
    output logic        ext_IR_we,
    output logic        ext_DM_we,
    output logic [7:0]  ext_addr,
    output logic [15:0] ext_data,
    output logic        test_normal,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        run_done,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
`ifdef LOADER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CPU_RST, RUN, DONE} state_t;

    state_t             state, state_d;
    logic               last_seen, last_seen_d;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_d;
    logic [15:0]        cnt_d, cnt_inc;
    logic               timeout_d;
    logic [7:0]         addr_d;
    logic [15:0]        data_d;
    logic               ir_we_d, dm_we_d, ready_d;
    logic               busy_d, run_done_d, cpu_reset_n_d, test_normal_d;
    logic               xfer;

    // Next state and next registered outputs
    always_comb begin
        state_d       = state;
        last_seen_d   = last_seen;
        rst_cnt_d     = rst_cnt;
        cnt_d         = cycle_count;
        timeout_d     = timeout;
        addr_d        = ext_addr;
        data_d        = ext_data;
        ir_we_d       = 1'b0;
        dm_we_d       = 1'b0;
        cnt_inc       = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        xfer          = (state == LOAD) && load_ready && load_valid;

        if (xfer) begin
            addr_d  = load_addr;
            data_d  = load_data;
            ir_we_d = !load_is_data;
            dm_we_d = load_is_data;
            if (load_last) begin
                last_seen_d = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    last_seen_d = 1'b0;
                end
            end
            // The last word's write cycle is spent here with ready low, so SETTLE never carries a write
            LOAD: begin
                if (last_seen) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d   = CPU_RST;
                rst_cnt_d = '0;
            end
            CPU_RST: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt + RST_W'(1);
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (cpu_done) begin
                    state_d = DONE;
                end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_CYCLES)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    last_seen_d = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d       = (state_d == LOAD) && !last_seen_d;
        busy_d        = (state_d == LOAD) || (state_d == SETTLE) ||
                        (state_d == CPU_RST) || (state_d == RUN);
        run_done_d    = (state_d == DONE);
        cpu_reset_n_d = (state_d == RUN) || (state_d == DONE);
        test_normal_d = (state_d != RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_seen   <= 1'b0;
            rst_cnt     <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            ext_addr    <= '0;
            ext_data    <= '0;
            ext_IR_we   <= 1'b0;
            ext_DM_we   <= 1'b0;
            load_ready  <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            cpu_reset_n <= 1'b0;
            test_normal <= 1'b1;
        end else begin
            state       <= state_d;
            last_seen   <= last_seen_d;
            rst_cnt     <= rst_cnt_d;
            cycle_count <= cnt_d;
            timeout     <= timeout_d;
            ext_addr    <= addr_d;
            ext_data    <= data_d;
            ext_IR_we   <= ir_we_d;
            ext_DM_we   <= dm_we_d;
            load_ready  <= ready_d;
            busy        <= busy_d;
            run_done    <= run_done_d;
            cpu_reset_n <= cpu_reset_n_d;
            test_normal <= test_normal_d;
        end
    end

endmodule
